game_session_ctrl: RTL

//  Parametrised session controller between the physics engine and display/audio.
//  It keeps a BCD score of configurable width, lives with bonus-life awards, and a level counter.
//  It runs the session FSM (SERVE/PLAY/CLEAR/OVER) and gates physics updates.
//  It also issues level-load requests and audio triggers.

---
 rtl/game_session_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/game_session_ctrl.sv
// Session controller: SERVE/PLAY/CLEAR/OVER sequencing, BCD score with bonus lives,
// level loading and audio cues. Define GAME_SESSION_HISCORE_EN to add HISCORE_BCD_o.
module game_session_ctrl #(
    parameter int SCORE_DIGITS = 4,
    parameter int LIVES_BITS   = 3,
    parameter int LIVES_INIT   = 5,
    parameter int LIVES_MAX    = 7,
    parameter int ROW_COUNT    = 6,
    parameter int ROW_BITS     = 3,
    parameter int PEND_BITS    = 6,
    parameter int LEVEL_BITS   = 3,
    parameter int BONUS_DIGIT  = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FRAME_DONE_i,
    input  logic                      PAUSE_i,
    input  logic                      BTN_RELEASE_i,
    input  logic                      START_i,
    input  logic                      STEP_DONE_i,
    input  logic                      HIT_WALL_i,
    input  logic                      HIT_PADDLE_i,
    input  logic                      HIT_BLOCK_i,
    input  logic [ROW_BITS-1:0]       HIT_ROW_i,
    input  logic                      BALL_LOST_i,
    input  logic [6:0]                BLOCKS_LEFT_i,
    input  logic                      LOAD_DONE_i,
    output logic                      STEP_REQ_o,
    output logic                      LOAD_LEVEL_o,
    output logic [2:0]                AUDIO_SEL_o,
    output logic                      AUDIO_TRIG_o,
    output logic [4*SCORE_DIGITS-1:0] SCORE_BCD_o,
    output logic [LIVES_BITS-1:0]     LIVES_o,
    output logic [LEVEL_BITS-1:0]     LEVEL_o,
    output logic [1:0]                STATE_o,
    output logic                      GAME_OVER_o
`ifdef GAME_SESSION_HISCORE_EN
    ,
    output logic [4*SCORE_DIGITS-1:0] HISCORE_BCD_o
`endif
);
    // state   | meaning
    // S_SERVE | ball parked on paddle, waiting for launch
    // S_PLAY  | ball in flight
    // S_CLEAR | level cleared, waiting for block memory reload
    // S_OVER  | no lives left, waiting for START
    localparam int SW  = 4 * SCORE_DIGITS;
    localparam int PSW = PEND_BITS + ROW_BITS + 2;
    localparam logic [PSW-1:0] PEND_MAX = PSW'((64'd1 << PEND_BITS) - 64'd1);

    typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_CLEAR = 2'd2, S_OVER = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         score_q, score_d, score_inc;
    logic [PEND_BITS-1:0]  pend_q, pend_d;
    logic [LIVES_BITS-1:0] lives_q, lives_d;
    logic [LEVEL_BITS-1:0] level_q, level_d;
    logic                  load_q, load_d, trig_q, trig_d, go_q, bsp_q, bsp_d;
    logic [2:0]            sel_q, sel_d, step_sel;
    logic                  score_full, bonus_carry, draining, bonus, active, restart;
    logic                  clear_go, lost_play, step_aud, add_pts;
    logic [PSW-1:0]        row_ext, pts, pend_sum;

    // Ripple BCD increment; the carry seen at BONUS_DIGIT marks a bonus-life boundary.
    always_comb begin
        logic c;
        c           = 1'b1;
        bonus_carry = 1'b0;
        score_inc   = score_q;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (i == BONUS_DIGIT) bonus_carry = c;
            if (c) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        score_full = c;
    end

    always_comb begin
        active    = STEP_DONE_i && (state_q == S_SERVE || state_q == S_PLAY);
        restart   = (state_q == S_OVER) && START_i;
        lost_play = STEP_DONE_i && (state_q == S_PLAY) && BALL_LOST_i;
        clear_go  = STEP_DONE_i && (state_q == S_PLAY) && !BALL_LOST_i && (BLOCKS_LEFT_i == 7'd0);
        draining  = (pend_q != '0);
        bonus     = draining && !score_full && bonus_carry && !restart;
        add_pts   = active && HIT_BLOCK_i && !BALL_LOST_i;
        row_ext   = PSW'(HIT_ROW_i);
        pts       = (row_ext >= PSW'(ROW_COUNT)) ? PSW'(1) : PSW'(ROW_COUNT) - row_ext;
        pend_sum  = PSW'(pend_q) + (add_pts ? pts : '0) - PSW'(draining);

        score_d = score_q;
        pend_d  = pend_q;
        if (draining && score_full) begin
            pend_d = '0;
        end else begin
            if (draining) score_d = score_inc;
            pend_d = (pend_sum > PEND_MAX) ? PEND_MAX[PEND_BITS-1:0] : pend_sum[PEND_BITS-1:0];
        end

        // A bonus landing on the same cycle as a lost ball cancels the loss.
        lives_d = lives_q;
        if (lost_play) begin
            if (!bonus) lives_d = (lives_q <= LIVES_BITS'(1)) ? '0 : lives_q - LIVES_BITS'(1);
        end else if (bonus && lives_q != LIVES_BITS'(LIVES_MAX)) begin
            lives_d = lives_q + LIVES_BITS'(1);
        end

        state_d = state_q;
        case (state_q)
            S_SERVE: if (BTN_RELEASE_i) state_d = S_PLAY;
            S_PLAY: begin
                if (lost_play) state_d = (lives_q <= LIVES_BITS'(1) && !bonus) ? S_OVER : S_SERVE;
                else if (clear_go) state_d = S_CLEAR;
            end
            S_CLEAR: if (LOAD_DONE_i) state_d = S_SERVE;
            S_OVER:  if (START_i) state_d = S_SERVE;
            default: state_d = S_SERVE;
        endcase

        level_d = clear_go ? level_q + LEVEL_BITS'(1) : level_q;
        load_d  = clear_go || restart;
        if (restart) begin
            score_d = '0;
            pend_d  = '0;
            lives_d = LIVES_BITS'(LIVES_INIT);
            level_d = '0;
        end

        if (BALL_LOST_i)       step_sel = 3'd2;
        else if (HIT_BLOCK_i)  step_sel = (row_ext >= PSW'(3)) ? 3'd7 : 3'd4 + row_ext[2:0];
        else if (HIT_PADDLE_i) step_sel = 3'd1;
        else                   step_sel = 3'd0;
        step_aud = active && (BALL_LOST_i || HIT_BLOCK_i || HIT_PADDLE_i || HIT_WALL_i);

        // Bonus sound waits for a cycle free of step audio.
        trig_d = 1'b0;
        sel_d  = sel_q;
        bsp_d  = bsp_q;
        if (step_aud) begin
            trig_d = 1'b1;
            sel_d  = step_sel;
            bsp_d  = bsp_q || bonus;
        end else if (bsp_q || bonus) begin
            trig_d = 1'b1;
            sel_d  = 3'd3;
            bsp_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_SERVE;
            score_q <= '0;
            pend_q  <= '0;
            lives_q <= LIVES_BITS'(LIVES_INIT);
            level_q <= '0;
            load_q  <= 1'b1;
            trig_q  <= 1'b0;
            sel_q   <= 3'd0;
            bsp_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            lives_q <= lives_d;
            level_q <= level_d;
            load_q  <= load_d;
            trig_q  <= trig_d;
            sel_q   <= sel_d;
            bsp_q   <= bsp_d;
            go_q    <= (state_d == S_OVER);
        end
    end

`ifdef GAME_SESSION_HISCORE_EN
    logic [SW-1:0] hi_q;
    // Packed BCD orders the same as its decimal value, so a plain compare suffices.
    always_ff @(posedge CLK) begin
        if (RESET) hi_q <= '0;
        else if (state_q != S_OVER && state_d == S_OVER && score_q > hi_q) hi_q <= score_q;
    end
    assign HISCORE_BCD_o = hi_q;
`endif

    assign STEP_REQ_o   = FRAME_DONE_i && !PAUSE_i && (state_q == S_SERVE || state_q == S_PLAY);
    assign LOAD_LEVEL_o = load_q;
    assign AUDIO_SEL_o  = sel_q;
    assign AUDIO_TRIG_o = trig_q;
    assign SCORE_BCD_o  = score_q;
    assign LIVES_o      = lives_q;
    assign LEVEL_o      = level_q;
    assign STATE_o      = state_q;
    assign GAME_OVER_o  = go_q;
endmodule
